if_stage: RTL and testbench

Instruction-fetch stage directly upstream of the decode stage. Holds the program counter and fetches one instruction at a time from instruction memory over a request/ready handshake. Delivers `instr` and `next_pc` (PC+4) through the IF/ID pipeline register. Handles hazard stalls from decode and control-flow redirects (branch/jump/jr) resolved downstream, flushing with the all-zero NOP, which decode treats as a non-writing instruction.

---
 rtl/if_stage.sv | 165 ++++++++++++++++
 tb/tb_if_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the program counter, issues one fetch at a
// time to instruction memory and loads the IF/ID register (instr, next_pc,
// valid) consumed by decode. Decode may stall the stage or redirect it to a
// new target. Flushed slots carry the all-zero NOP with valid low.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] next_pc,
    output logic        valid
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

    // Targets are word addresses; the two low bits are ignored.
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    // Sequential successor, wrapping modulo 2^32.
    function automatic logic [31:0] inc_pc(input logic [31:0] a);
        return a + 32'd4;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;

    logic        deliver;
    logic [31:0] deliver_word;
    logic [31:0] pc_tgt;
    logic [31:0] pc_inc;

    assign pc_tgt = align_pc(redirect_pc);
    assign pc_inc = inc_pc(pc_q);

    // Fetch FSM: next state, next PC, and which word (if any) is delivered.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        deliver      = 1'b0;
        deliver_word = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (redirect) pc_d = pc_tgt;
                state_d = S_REQ;
            end
            S_REQ: begin
                // Request leaves this cycle; a redirect now makes its response stale.
                if (redirect) begin
                    pc_d    = pc_tgt;
                    state_d = S_DROP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pc_d    = pc_tgt;
                        state_d = S_REQ;
                    end else if (stall) begin
                        buf_d   = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        deliver      = 1'b1;
                        deliver_word = imem_rdata;
                        pc_d         = pc_inc;
                        state_d      = S_REQ;
                    end
                end else if (redirect) begin
                    pc_d    = pc_tgt;
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = pc_tgt;
                    state_d = S_REQ;
                end else if (!stall) begin
                    deliver      = 1'b1;
                    deliver_word = buf_q;
                    pc_d         = pc_inc;
                    state_d      = S_REQ;
                end
            end
            S_DROP: begin
                // Still waiting for the stale response; later redirects retarget.
                if (redirect) pc_d = pc_tgt;
                if (imem_ready) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // IF/ID next value: flush beats hold beats load; otherwise a bubble.
    always_comb begin
        instr_d = 32'h0;
        npc_d   = 32'h0;
        valid_d = 1'b0;
        if (redirect) begin
            instr_d = 32'h0;
            npc_d   = 32'h0;
            valid_d = 1'b0;
        end else if (stall) begin
            instr_d = instr_q;
            npc_d   = npc_q;
            valid_d = valid_q;
        end else if (deliver) begin
            instr_d = deliver_word;
            npc_d   = pc_inc;
            valid_d = 1'b1;
        end
    end

    // Fetch control state: PC, FSM state and the stalled-response buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    // IF/ID pipeline register boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= 32'h0;
            npc_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign next_pc   = npc_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a behavioural instruction memory with programmable
// latency, directed stall/redirect/reset sequences, and two scoreboard
// monitors (fetch addresses and IF/ID deliveries) fed by the stimulus.
module tb_if_stage;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] npc;
    } out_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] next_pc;
    logic        valid;

    logic        mem_rdy;
    logic [31:0] mem_data;
    int          lat;
    int          nchk;
    int          nerr;
    logic        held;

    logic [31:0] exp_addr_q[$];
    out_t        exp_out_q[$];

    if_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .next_pc    (next_pc),
        .valid      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory drops any in-flight response while reset is high.
    assign imem_ready = mem_rdy & ~rst;
    assign imem_rdata = mem_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h1111_1111;
            32'h0000_0104: return 32'h2222_2222;
            default:       return {a[15:0], 16'hC0DE};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] a);
        int n;
        n = 0;
        while (!(imem_req === 1'b1 && imem_addr === a) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            nchk++;
            nerr++;
            $display("FAIL wait_req_timeout: no request to %h within 50 cycles", a);
        end
    endtask

    // Instruction memory: answers each request 'lat' cycles later for one cycle.
    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend     = 1'b0;
        cnt      = 0;
        paddr    = 32'h0;
        mem_rdy  = 1'b0;
        mem_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_rdy = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cnt <= 1) begin
                        mem_rdy  = 1'b1;
                        mem_data = mem_word(paddr);
                        pend     = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (imem_req) begin
                    pend  = 1'b1;
                    cnt   = lat;
                    paddr = imem_addr;
                end
            end
        end
    end

    // Address monitor: every request must match the next expected fetch address.
    always @(negedge clk) begin
        if (!rst && imem_req) begin
            if (exp_addr_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_req: addr %h, no fetch expected", imem_addr);
            end else begin
                chk("imem_addr", imem_addr, exp_addr_q.pop_front());
            end
        end
    end

    // Delivery monitor: each newly presented IF/ID instruction must match the queue head.
    always @(negedge clk) begin
        out_t e;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (valid && !held) begin
                if (exp_out_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_valid: instr %h next_pc %h, no delivery expected", instr, next_pc);
                end else begin
                    e = exp_out_q.pop_front();
                    chk("instr", instr, e.ins);
                    chk("next_pc", next_pc, e.npc);
                end
            end
            held = valid && stall && !redirect;
        end
    end

    initial begin
        nchk        = 0;
        nerr        = 0;
        held        = 1'b0;
        lat         = 1;
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1 rst = 1'b1;
        #1;
        chk("rst_instr", instr, 32'h0);
        chk("rst_next_pc", next_pc, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);

        // Basic fetch with 1-cycle memory from RESET_PC.
        exp_addr_q.push_back(32'h0000_0100);
        exp_addr_q.push_back(32'h0000_0104);
        exp_out_q.push_back('{32'h1111_1111, 32'h0000_0104});
        exp_out_q.push_back('{32'h2222_2222, 32'h0000_0108});
        exp_addr_q.push_back(32'h0000_0108);
        step();
        step();
        #2 rst = 1'b0;
        wait_req(32'h0000_0108);

        // Response arrives under a 3-cycle stall, then delivered from the buffer.
        step();
        stall = 1'b1;
        lat   = 3;
        exp_out_q.push_back('{mem_word(32'h0000_0108), 32'h0000_010C});
        exp_addr_q.push_back(32'h0000_010C);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", {31'h0, valid}, 32'h0);
            chk("stall_no_req", {31'h0, imem_req}, 32'h0);
        end
        stall = 1'b0;
        wait_req(32'h0000_010C);

        // Redirect while waiting with no response: stale response must be dropped.
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        exp_addr_q.push_back(32'h0000_0200);
        step();
        redirect = 1'b0;
        lat      = 1;
        chk("redir_flush_valid", {31'h0, valid}, 32'h0);
        chk("drop_no_req0", {31'h0, imem_req}, 32'h0);
        step();
        chk("drop_no_req1", {31'h0, imem_req}, 32'h0);
        wait_req(32'h0000_0200);

        // Redirect together with stall in HOLD: buffer discarded, fetch the target.
        step();
        stall = 1'b1;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_out_q.push_back('{mem_word(32'hFFFF_FFFC), 32'h0000_0000});
        exp_addr_q.push_back(32'h0000_0000);
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        chk("hold_redir_valid", {31'h0, valid}, 32'h0);

        // PC wrap, then asynchronous reset in WAIT while IF/ID holds a valid word.
        wait_req(32'h0000_0000);
        stall = 1'b1;
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_instr", instr, 32'h0);
        chk("arst_next_pc", next_pc, 32'h0);
        chk("arst_valid", {31'h0, valid}, 32'h0);
        chk("arst_req", {31'h0, imem_req}, 32'h0);
        exp_addr_q.push_back(32'h0000_0100);
        exp_out_q.push_back('{32'h1111_1111, 32'h0000_0104});
        exp_addr_q.push_back(32'h0000_0104);
        stall = 1'b0;
        step();
        #2 rst = 1'b0;
        wait_req(32'h0000_0104);
        step();

        chk("addr_q_empty", exp_addr_q.size(), 32'h0);
        chk("out_q_empty", exp_out_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
